// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types: FSM state encoding and port ids.
// Reused by the dmem arbiter and future imem/regfile controllers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin with last-grant pointer, or fixed p0 priority.
// Ports: i_req0/i_req1 requests, i_upd/i_upd_id pointer update, o_any/o_win result.
module rr_arb2
  import mem_ctrl_pkg::*;
#(
  parameter int P0_PRIO = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_req0,
  input  logic     i_req1,
  input  logic     i_upd,
  input  port_id_t i_upd_id,
  output logic     o_any,
  output port_id_t o_win
);

  port_id_t r_last;
  port_id_t w_tie;

  // Pointer starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT1;
    end else if (i_upd) begin
      r_last <= i_upd_id;
    end
  end

  assign w_tie = (P0_PRIO != 0)   ? PORT0 :
                 (r_last == PORT1) ? PORT0 : PORT1;

  always_comb begin
    o_any = i_req0 | i_req1;
    o_win = PORT0;
    unique case (1'b1)
      (i_req0 & i_req1):  o_win = w_tie;
      (i_req0 & ~i_req1): o_win = PORT0;
      (~i_req0 & i_req1): o_win = PORT1;
      default:            o_win = PORT0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE->ACCESS->RESP, one access per 3 cycles.
// Ports: p0_*/p1_* requester side (req/we/addr/wdata in, gnt/rvalid/rdata out), dm_* to dmem.
module dmem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int P0_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [3:0]    p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic [3:0]    p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [3:0]    dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  mem_state_e    r_state;
  mem_state_e    w_next;
  logic [3:0]    r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  port_id_t      r_id;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_any;
  port_id_t      w_win;
  logic          w_upd;

  assign w_upd = (r_state == ST_ACCESS);

  rr_arb2 #(
    .P0_PRIO (P0_PRIO)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req0   (p0_req),
    .i_req1   (p1_req),
    .i_upd    (w_upd),
    .i_upd_id (r_id),
    .o_any    (w_any),
    .o_win    (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request fields are captured only in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_id    <= PORT0;
    end else if ((r_state == ST_IDLE) && w_any) begin
      r_id    <= w_win;
      r_we    <= (w_win == PORT1) ? p1_we    : p0_we;
      r_addr  <= (w_win == PORT1) ? p1_addr  : p0_addr;
      r_wdata <= (w_win == PORT1) ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_id == PORT0) r_rdata0 <= dm_rdata;
      else               r_rdata1 <= dm_rdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    dm_we     = '0;
    dm_addr   = r_addr;
    dm_wdata  = r_wdata;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        dm_we  = r_we;
        p0_gnt = (r_id == PORT0);
        p1_gnt = (r_id == PORT1);
        w_next = ST_RESP;
      end
      ST_RESP: begin
        p0_rvalid = (r_id == PORT0);
        p1_rvalid = (r_id == PORT1);
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read data bypasses the register during rvalid, then holds.
  assign p0_rdata = p0_rvalid ? dm_rdata : r_rdata0;
  assign p1_rdata = p1_rvalid ? dm_rdata : r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: round-robin instance with a dmem model,
// plus a P0_PRIO=1 instance for the fixed-priority grant behaviour.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [3:0]  p0_we = '0, p1_we = '0;
  logic [31:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] dm_rdata = '0;

  logic        q0_req = 1'b0, q1_req = 1'b0;
  logic [31:0] q_addr = 32'h40;
  logic        q0_gnt, q1_gnt, q0_rvalid, q1_rvalid;
  logic [31:0] q0_rdata, q1_rdata;
  logic [3:0]  q_dm_we;
  logic [31:0] q_dm_addr, q_dm_wdata;
  logic [31:0] q_dm_rdata = '0;

  logic [31:0] mem [0:255];

  int checks = 0;
  int failures = 0;
  int we_cycles = 0;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .P0_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .P0_PRIO(1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .p0_req(q0_req), .p0_we(4'h0), .p0_addr(q_addr), .p0_wdata(32'h0),
    .p0_gnt(q0_gnt), .p0_rvalid(q0_rvalid), .p0_rdata(q0_rdata),
    .p1_req(q1_req), .p1_we(4'h0), .p1_addr(q_addr), .p1_wdata(32'h0),
    .p1_gnt(q1_gnt), .p1_rvalid(q1_rvalid), .p1_rdata(q1_rdata),
    .dm_we(q_dm_we), .dm_addr(q_dm_addr), .dm_wdata(q_dm_wdata),
    .dm_rdata(q_dm_rdata)
  );

  // Synchronous dmem: byte-enable write, registered read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_we[b]) mem[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    dm_rdata <= mem[dm_addr[9:2]];
  end

  always @(negedge clk)
    if (dm_we != 4'h0) we_cycles++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pop the expected response whenever a port presents rvalid.
  always @(negedge clk) begin
    if (p0_rvalid) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL p0_unexpected_rvalid actual=1 required=0");
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (e.chk) chk("p0_rdata", p0_rdata, e.data);
      end
    end
    if (p1_rvalid) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL p1_unexpected_rvalid actual=1 required=0");
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (e.chk) chk("p1_rdata", p1_rdata, e.data);
      end
    end
  end

  // One request: push expectation, hold req until gnt, check latencies.
  task automatic xact(input int port, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input bit dchk,
                      input int lat);
    exp_t e;
    int   n;
    bit   got;
    e.chk  = dchk;
    e.data = exp;
    if (port == 0) begin
      q0.push_back(e);
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      q1.push_back(e);
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = (port == 0) ? p0_gnt : p1_gnt;
    end
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL gnt_timeout port=%0d actual=0 required=1", port);
    end else begin
      if (lat != 0) chk($sformatf("gnt_latency_p%0d", port), n, lat);
      @(negedge clk);
      chk($sformatf("rvalid_timing_p%0d", port),
          (port == 0) ? {31'b0, p0_rvalid} : {31'b0, p1_rvalid}, 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, n, w0, rv;
    bit got;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h08] = 32'h11223344;
    mem[8'h0C] = 32'hCAFEF00D;

    #3;
    chk("rst_dm_we", {28'b0, dm_we}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_gnt", {30'b0, p0_gnt, p1_gnt}, 32'h0);
    chk("rst_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First tie after reset: p0 wins, p1 follows three cycles later.
    fork
      xact(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1);
      xact(1, 4'h0, 32'h20, 32'h0, 32'h11223344, 1'b1, 4);
    join

    xact(1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1);

    w0 = we_cycles;
    xact(0, 4'b0010, 32'h20, 32'h0000AB00, 32'h0, 1'b0, 1);
    chk("write_we_cycles", we_cycles - w0, 32'd1);
    xact(0, 4'h0, 32'h20, 32'h0, 32'h1122AB44, 1'b1, 1);
    repeat (3) @(negedge clk);
    chk("p0_rdata_hold", p0_rdata, 32'h1122AB44);

    // Last grant was p0, so this tie goes to p1.
    fork
      xact(1, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b1, 1);
      xact(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 4);
    join

    // Reset during ACCESS of a write aborts it.
    p0_we = 4'hF; p0_addr = 32'h30; p0_wdata = 32'h12345678; p0_req = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_pre_we", {28'b0, dm_we}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("abort_dm_we", {28'b0, dm_we}, 32'h0);
    chk("abort_gnt", {31'b0, p0_gnt}, 32'h0);
    p0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid) rv++;
    end
    chk("abort_no_rvalid", rv, 32'd0);
    xact(0, 4'h0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b1, 1);

    // Fixed priority: p1 starves while p0 is held.
    c0 = 0; c1 = 0;
    q0_req = 1'b1; q1_req = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (q0_gnt) c0++;
      if (q1_gnt) c1++;
    end
    chk("prio_p1_starved", c1, 32'd0);
    chk("prio_p0_grants", c0, 32'd5);
    q0_req = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 3) begin
      @(negedge clk);
      n++;
      got = q1_gnt;
    end
    chk("prio_p1_after_drop", {31'b0, got}, 32'd1);
    q1_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width; P0_PRIO, default 0, 1 = port 0 always wins, 0 = round-robin.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 p0_req  input  1  port 0 (core load/store) request; held high with stable fields until p0_gnt.
REQ-005 p0_we  input  4  port 0 byte write enables; 4'b0000 = read.
REQ-006 p0_addr  input  AW  port 0 byte address.
REQ-007 p0_wdata  input  DW  port 0 write data.
REQ-008 p0_gnt  output  1  one-cycle pulse: port 0 request accepted.
REQ-009 p0_rvalid  output  1  one-cycle pulse: port 0 access complete, p0_rdata valid.
REQ-010 p0_rdata  output  DW  port 0 read data.
REQ-011 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata SHALL mirror REQ-004..010 for port 1 (debug/loader).
REQ-012 dm_we  output  4  to dmem we.
REQ-013 dm_addr  output  AW  to dmem daddr.
REQ-014 dm_wdata  output  DW  to dmem indata.
REQ-015 dm_rdata  input  DW  from dmem outdata; valid the cycle after address is presented.

Function
REQ-016 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-017 IDLE: with no req, stay IDLE, drive dm_we=0; with any req, select winner, latch its we/addr/wdata/port id, go ACCESS.
REQ-018 Round-robin: both req in same cycle -> grant port not granted last; last-grant pointer resets to port 1, so port 0 wins first contention.
REQ-019 P0_PRIO=1: port 0 wins every contention; port 1 served only when p0_req low.
REQ-020 ACCESS (1 cycle): drive latched we/addr/wdata onto dm_*, pulse winner's gnt, update last-grant pointer, go RESP.
REQ-021 RESP (1 cycle): drive dm_we=0, capture dm_rdata into winner's rdata register, pulse winner's rvalid, go IDLE.
REQ-022 Fixed latency: gnt 1 cycle after req sampled in IDLE, rvalid 2 cycles after; throughput one access per 3 cycles.
REQ-023 dm_we SHALL be nonzero only in ACCESS; each write SHALL hit dmem exactly once.
REQ-024 Writes SHALL also produce rvalid; rdata for a write = dm_rdata sampled in RESP (don't-care to requester).
REQ-025 Loser's req SHALL stay pending, served at next IDLE; no request dropped.
REQ-026 Request fields SHALL be sampled only in IDLE; changes during ACCESS/RESP SHALL not affect the current access.
REQ-027 Each port's rdata SHALL hold its last value until that port's next rvalid.
REQ-028 Requester deasserting req before gnt: if already latched, the access still completes (gnt/rvalid still issued).
REQ-029 Starvation bound (round-robin): a held request SHALL be granted within 2 arbitration rounds (≤6 cycles).

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, dm_we=0, dm_addr=0, dm_wdata=0, all gnt/rvalid=0, p0_rdata=p1_rdata=0, last-grant=port 1.
REQ-031 Reset mid-ACCESS SHALL abort the write (dm_we=0 immediately); no rvalid for the aborted access after release.
REQ-032 First arbitration SHALL occur on the first rising edge with rst_n high.

Structure
REQ-033 State encoding (IDLE/ACCESS/RESP) and port-id constants SHALL live in shared package mem_ctrl_pkg, reused by future imem/regfile controllers.
REQ-034 Winner selection SHALL be sub-module rr_arb2 (2-input round-robin, pointer + P0_PRIO); remaining logic stays flat.

Verification
REQ-035 Single read: p1_req, we=0, addr=0x10, dmem[0x10]=0xDEADBEEF -> p1_gnt at +1, p1_rvalid at +2, p1_rdata=0xDEADBEEF.
REQ-036 Byte write: p0 we=4'b0010, addr=0x20, wdata=0x0000AB00 over 0x11223344 -> readback 0x1122AB44; dm_we nonzero exactly one cycle.
REQ-037 Contention after reset: both req same cycle -> p0 granted first, p1 granted at next IDLE (3 cycles later); next tie goes to the other port.
REQ-038 P0_PRIO=1, p0_req held continuously -> p1 never granted; drop p0_req -> p1 granted within 3 cycles.
REQ-039 rst_n low during ACCESS of a write to 0x30 -> dm_we=0 same cycle, no rvalid after release, next p0 read of 0x30 returns unchanged data.
